// File: rtl/spi_slave_mem_bridge.sv
// spi_slave_mem_bridge
//   SPI mode 0 target in the clk_core_i domain. Decodes WRITE (0x02) and
//   READ (0x03) frames (8-bit cmd, 16-bit address MSB-first, then data bytes,
//   address auto-increments) into byte accesses on a req/ack memory port.
//   Optional feature macro: SPI_SLAVE_RDSR_EN adds read-status command 0x05
//   returning {6'b0, underrun_sticky, overrun_sticky}.
// Ports:
//   clk_core_i, rst_n_i                   core clock, async active-low reset
//   spi_sclk_i, spi_cs_i, spi_mosi_i      SPI inputs (asynchronous to core)
//   spi_miso_o, spi_miso_oe_o             SPI data out and pad enable
//   mem_req_o/we_o/addr_o/wdata_o         memory request, held until ack
//   mem_rdata_i, mem_ack_i                memory response
//   busy_o, frame_done_o, err_o           status: in frame, end pulse, error pulse
//
// state      | meaning
// S_IDLE     | no frame; first rise with cs low starts a command
// S_CMD      | shifting in the command byte
// S_ADDR     | shifting in the 16-bit address
// S_WR_DATA  | each completed byte becomes a memory write
// S_RD_DATA  | prefetched read bytes are shifted out on MISO
// S_DISCARD  | unknown command, ignore everything until cs rises
// S_STATUS   | status byte shifted out (SPI_SLAVE_RDSR_EN only)
module spi_slave_mem_bridge #(
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_core_i,
  input  logic                  rst_n_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WR_DATA, S_RD_DATA, S_DISCARD, S_STATUS
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [14:0]            sh_q, sh_d;
  logic                   addr_hi_q, addr_hi_d;
  logic                   wr_mode_q, wr_mode_d;
  logic                   load_pend_q, load_pend_d;
  logic [ADDR_WIDTH-1:0]  addr_reg_q, addr_reg_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]             tx_q, tx_d;
  logic [7:0]             pf_data_q, pf_data_d;
  logic                   pf_valid_q, pf_valid_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  logic        sclk_s, cs_s, mosi_s, rise, fall, byte_done;
  logic        rd_trig, underrun, overrun;
  logic [7:0]  byte_in;
  logic [15:0] word_in;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_prev_q;
  assign fall      = ~sclk_s & sclk_prev_q;
  assign byte_done = (bit_cnt_q == 3'd7);
  assign byte_in   = {sh_q[6:0], mosi_s};
  assign word_in   = {sh_q, mosi_s};

`ifdef SPI_SLAVE_RDSR_EN
  logic under_q, under_d, over_q, over_d;

  always_comb begin
    under_d = under_q | underrun;
    over_d  = over_q | overrun;
    if (cs_s && state_q == S_STATUS) begin
      under_d = 1'b0;
      over_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      under_q <= under_d;
      over_q  <= over_d;
    end
  end
`endif

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    sclk_prev_d = sclk_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    addr_hi_d   = addr_hi_q;
    wr_mode_d   = wr_mode_q;
    load_pend_d = load_pend_q;
    addr_reg_d  = addr_reg_q;
    mem_addr_d  = mem_addr_q;
    tx_d        = tx_q;
    pf_data_d   = pf_data_q;
    pf_valid_d  = pf_valid_q;
    wdata_d     = wdata_q;
    req_d       = req_q;
    we_d        = we_q;
    done_d      = 1'b0;
    rd_trig     = 1'b0;
    underrun    = 1'b0;
    overrun     = 1'b0;

    // The memory side runs independently of cs: an access started in a frame
    // always completes, even after the frame has ended.
    if (req_q && mem_ack_i) begin
      req_d      = 1'b0;
      addr_reg_d = addr_reg_q + ADDR_ONE;
      if (!we_q && state_q == S_RD_DATA) begin
        pf_data_d  = mem_rdata_i;
        pf_valid_d = 1'b1;
      end
    end

    if (cs_s) begin
      state_d     = S_IDLE;
      bit_cnt_d   = 3'd0;
      load_pend_d = 1'b0;
      done_d      = (state_q != S_IDLE);
    end else begin
      if (rise) begin
        sh_d      = {sh_q[13:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        case (state_q)
          S_IDLE: state_d = S_CMD;
          S_CMD: begin
            if (byte_done) begin
              addr_hi_d = 1'b0;
              case (byte_in)
                8'h02: begin state_d = S_ADDR; wr_mode_d = 1'b1; end
                8'h03: begin state_d = S_ADDR; wr_mode_d = 1'b0; end
`ifdef SPI_SLAVE_RDSR_EN
                8'h05: begin state_d = S_STATUS; load_pend_d = 1'b1; end
`endif
                default: state_d = S_DISCARD;
              endcase
            end
          end
          S_ADDR: begin
            if (byte_done) begin
              if (!addr_hi_q) begin
                addr_hi_d = 1'b1;
              end else begin
                addr_reg_d = word_in[ADDR_WIDTH-1:0];
                pf_valid_d = 1'b0;
                if (wr_mode_q) begin
                  state_d = S_WR_DATA;
                end else begin
                  state_d     = S_RD_DATA;
                  load_pend_d = 1'b1;
                  rd_trig     = 1'b1;
                end
              end
            end
          end
          S_WR_DATA: begin
            if (byte_done) begin
              if (req_q) begin
                overrun = 1'b1;
              end else begin
                req_d      = 1'b1;
                we_d       = 1'b1;
                mem_addr_d = addr_reg_q;
                wdata_d    = byte_in;
              end
            end
          end
          S_RD_DATA: if (byte_done) load_pend_d = 1'b1;
          default: ;
        endcase
      end

      if (fall) begin
        if (load_pend_q && state_q == S_RD_DATA) begin
          load_pend_d = 1'b0;
          rd_trig     = 1'b1;
          if (pf_valid_q) begin
            tx_d       = pf_data_q;
            pf_valid_d = 1'b0;
          end else begin
            tx_d     = 8'hFF;
            underrun = 1'b1;
          end
        end
`ifdef SPI_SLAVE_RDSR_EN
        else if (load_pend_q && state_q == S_STATUS) begin
          load_pend_d = 1'b0;
          tx_d        = {6'b0, under_q, over_q};
        end
`endif
        else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end

    // A read still in flight at a byte boundary will fill the prefetch buffer
    // itself, so no second request is queued behind it.
    if (rd_trig && !req_q) begin
      req_d      = 1'b1;
      we_d       = 1'b0;
      mem_addr_d = addr_reg_d;
    end

    err_d = underrun | overrun;
  end

  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      sh_q        <= '0;
      addr_hi_q   <= 1'b0;
      wr_mode_q   <= 1'b0;
      load_pend_q <= 1'b0;
      addr_reg_q  <= '0;
      mem_addr_q  <= '0;
      tx_q        <= 8'd0;
      pf_data_q   <= 8'd0;
      pf_valid_q  <= 1'b0;
      wdata_q     <= 8'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      addr_hi_q   <= addr_hi_d;
      wr_mode_q   <= wr_mode_d;
      load_pend_q <= load_pend_d;
      addr_reg_q  <= addr_reg_d;
      mem_addr_q  <= mem_addr_d;
      tx_q        <= tx_d;
      pf_data_q   <= pf_data_d;
      pf_valid_q  <= pf_valid_d;
      wdata_q     <= wdata_d;
      req_q       <= req_d;
      we_q        <= we_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign spi_miso_o    = tx_q[7];
  assign spi_miso_oe_o = ~spi_cs_i & ((state_q == S_RD_DATA) | (state_q == S_STATUS));
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = wdata_q;
  assign busy_o        = (state_q != S_IDLE);
  assign frame_done_o  = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_spi_slave_mem_bridge.sv
// Directed bench for spi_slave_mem_bridge: acts as SPI host (half period of
// 8 core cycles) and as a byte memory that acks one cycle after a request.
module tb_spi_slave_mem_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, oe, req, we, busy, fdone, err;
  logic [15:0] maddr;
  logic [7:0]  wdata;
  logic [7:0]  rdata = 8'd0;
  logic        ack = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_slave_mem_bridge #(.ADDR_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk_core_i(clk), .rst_n_i(rst_n),
    .spi_sclk_i(sclk), .spi_cs_i(cs), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(oe),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr), .mem_wdata_o(wdata),
    .mem_rdata_i(rdata), .mem_ack_i(ack),
    .busy_o(busy), .frame_done_o(fdone), .err_o(err)
  );

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    case (a)
      16'hFFFF: mem_val = 8'h11;
      16'h0000: mem_val = 8'h22;
      16'h0020: mem_val = 8'h5C;
      default:  mem_val = a[7:0] ^ 8'h3C;
    endcase
  endfunction

  // Memory responder and event monitors, all acting on the falling edge.
  bit          ack_en = 1'b1;
  logic [15:0] wr_addr [0:15];
  logic [7:0]  wr_data [0:15];
  logic [15:0] rd_addr [0:15];
  int          wr_n = 0, rd_n = 0, err_n = 0, fd_n = 0, rise_n = 0, oe_n = 0;
  logic        req_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (err) err_n++;
    if (fdone) fd_n++;
    if (oe) oe_n++;
    if (req && !req_prev) rise_n++;
    req_prev = req;
    if (req && !ack && ack_en) begin
      ack   = 1'b1;
      rdata = mem_val(maddr);
      if (we) begin
        if (wr_n < 16) begin wr_addr[wr_n] = maddr; wr_data[wr_n] = wdata; end
        wr_n++;
      end else begin
        if (rd_n < 16) rd_addr[rd_n] = maddr;
        rd_n++;
      end
    end else begin
      ack = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      cyc(8);
      rx[i] = miso;
      sclk = 1'b1;
      cyc(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs = 1'b0;
    cyc(4);
  endtask

  task automatic frame_end();
    cyc(8);
    cs = 1'b1;
    cyc(10);
  endtask

  logic [7:0] rx1, rx2, dmy;
  int w0, r0, e0, f0, q0, o0;

  initial begin
    // reset state
    cyc(3);
    chk("reset_outs", {miso, oe, req, we, maddr, wdata, busy, fdone, err}, 0);
    rst_n = 1'b1;
    cyc(5);

    // reset after 12 bits of a write frame
    frame_start();
    spi_byte(8'h02, dmy);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b0; cyc(8); sclk = 1'b1; cyc(8); sclk = 1'b0;
    end
    cyc(4);
    chk("busy_mid", busy, 1);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst_outs", {miso, oe, req, we, maddr, wdata, busy, fdone, err}, 0);
    cs = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    w0 = wr_n;
    frame_start();
    spi_byte(8'h02, dmy); spi_byte(8'h00, dmy); spi_byte(8'h30, dmy); spi_byte(8'hC3, dmy);
    frame_end();
    chk("post_rst_wr_n", wr_n - w0, 1);
    chk("post_rst_addr", wr_addr[w0], 16'h0030);
    chk("post_rst_data", wr_data[w0], 8'hC3);

    // write two bytes with auto-increment
    w0 = wr_n; e0 = err_n; f0 = fd_n;
    frame_start();
    spi_byte(8'h02, dmy); spi_byte(8'h00, dmy); spi_byte(8'h10, dmy);
    spi_byte(8'hA5, dmy); spi_byte(8'h5A, dmy);
    frame_end();
    chk("wr_n", wr_n - w0, 2);
    chk("wr_addr0", wr_addr[w0], 16'h0010);
    chk("wr_data0", wr_data[w0], 8'hA5);
    chk("wr_addr1", wr_addr[w0+1], 16'h0011);
    chk("wr_data1", wr_data[w0+1], 8'h5A);
    chk("wr_err", err_n - e0, 0);
    chk("wr_fdone", fd_n - f0, 1);
    chk("wr_busy_after", busy, 0);

    // read across the address wrap
    r0 = rd_n; e0 = err_n;
    frame_start();
    spi_byte(8'h03, dmy); spi_byte(8'hFF, dmy); spi_byte(8'hFF, dmy);
    spi_byte(8'h00, rx1); spi_byte(8'h00, rx2);
    frame_end();
    chk("rd_byte0", rx1, 8'h11);
    chk("rd_byte1", rx2, 8'h22);
    chk("rd_addr0", rd_addr[r0], 16'hFFFF);
    chk("rd_addr1_wrap", rd_addr[r0+1], 16'h0000);
    chk("rd_err", err_n - e0, 0);

    // read underrun: first read acked one byte-time late
    e0 = err_n; f0 = fd_n;
    ack_en = 1'b0;
    frame_start();
    spi_byte(8'h03, dmy); spi_byte(8'h00, dmy); spi_byte(8'h20, dmy);
    cyc(6);
    ack_en = 1'b1;
    spi_byte(8'h00, rx1); spi_byte(8'h00, rx2);
    frame_end();
    chk("ur_byte0", rx1, 8'hFF);
    chk("ur_byte1", rx2, 8'h5C);
    chk("ur_err", err_n - e0, 1);
    chk("ur_fdone", fd_n - f0, 1);

    // write overrun: ack withheld across the frame end
    w0 = wr_n; e0 = err_n; f0 = fd_n;
    ack_en = 1'b0;
    frame_start();
    spi_byte(8'h02, dmy); spi_byte(8'h00, dmy); spi_byte(8'h40, dmy);
    spi_byte(8'h11, dmy); spi_byte(8'h22, dmy);
    cyc(4);
    chk("ov_err", err_n - e0, 1);
    frame_end();
    chk("ov_req_held", req, 1);
    chk("ov_fdone", fd_n - f0, 1);
    ack_en = 1'b1;
    cyc(4);
    chk("ov_req_drop", req, 0);
    chk("ov_wr_n", wr_n - w0, 1);
    chk("ov_addr", wr_addr[w0], 16'h0040);
    chk("ov_data", wr_data[w0], 8'h11);

    // unknown command is discarded
    q0 = rise_n; o0 = oe_n; f0 = fd_n;
    frame_start();
    spi_byte(8'h9F, dmy); spi_byte(8'h00, dmy); spi_byte(8'h01, dmy);
    cyc(2);
    chk("disc_busy", busy, 1);
    spi_byte(8'h02, dmy);
    frame_end();
    chk("disc_req", rise_n - q0, 0);
    chk("disc_oe", oe_n - o0, 0);
    chk("disc_fdone", fd_n - f0, 1);

    // read-status command
    q0 = rise_n; o0 = oe_n;
    frame_start();
    spi_byte(8'h05, dmy); spi_byte(8'h00, rx1);
    frame_end();
`ifdef SPI_SLAVE_RDSR_EN
    chk("rdsr_sticky", rx1, 8'h03);
    chk("rdsr_req", rise_n - q0, 0);
    frame_start();
    spi_byte(8'h05, dmy); spi_byte(8'h00, rx2);
    frame_end();
    chk("rdsr_cleared", rx2, 8'h00);
`else
    chk("rdsr_off_req", rise_n - q0, 0);
    chk("rdsr_off_oe", oe_n - o0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
